// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg -- shared definitions for the interrupt controller.
//   * register word addresses
//   * controller state encoding
//   * STATUS register layout {state, cpu_irq}
//   * lowest_set(): index of the lowest set bit of a 32-bit vector
package intr_ctrl_pkg;

   localparam logic [1:0] ADDR_ENABLE  = 2'd0;
   localparam logic [1:0] ADDR_PENDING = 2'd1;
   localparam logic [1:0] ADDR_CLAIM   = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ASSERT    = 2'd1,
      ST_INSERVICE = 2'd2
   } state_e;

   // STATUS word: bit 0 = cpu_irq, bits 2:1 = state, rest reads 0
   typedef struct packed {
      logic [28:0] rsvd;
      state_e      state;
      logic        cpu_irq;
   } status_t;

   // Lowest index wins; scanning downward leaves the smallest set index last.
   function automatic logic [4:0] lowest_set(input logic [31:0] vec);
      logic [4:0] idx;
      idx = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (vec[i]) begin
            idx = 5'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/intr_edge_det.sv
// intr_edge_det -- rising-edge detector for the interrupt sources.
// Ports:
//   CLK      : clock, rising edge
//   RST_N    : synchronous active-low reset
//   src_irq  : raw source levels (NUM_SRC bits)
//   src_edge : one-cycle pulse per source on a detected 0->1 transition
// Build option: define INTR_CTRL_SYNC_EN to insert a two-flop synchronizer
// ahead of the detector (two extra cycles of latency).
module intr_edge_det #(
   parameter int NUM_SRC = 8
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_SRC-1:0] src_irq,
   output logic [NUM_SRC-1:0] src_edge
);

`ifdef INTR_CTRL_SYNC_EN
   // History must only be trusted once the synchronizer has flushed its
   // reset zeros, otherwise a source already high would look like an edge.
   localparam int PRIME_W = 3;

   logic [NUM_SRC-1:0] sync1_q, sync1_d;
   logic [NUM_SRC-1:0] sync2_q, sync2_d;
   logic [NUM_SRC-1:0] sample_s;

   // Synchronizer next-state and detector sample point
   always_comb begin
      sync1_d  = src_irq;
      sync2_d  = sync1_q;
      sample_s = sync2_q;
   end

   // Synchronizer flops
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         sync1_q <= {NUM_SRC{1'b0}};
         sync2_q <= {NUM_SRC{1'b0}};
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end
`else
   localparam int PRIME_W = 1;

   logic [NUM_SRC-1:0] sample_s;

   // Sources are sampled directly
   always_comb begin
      sample_s = src_irq;
   end
`endif

   localparam logic [PRIME_W-1:0] PRIME_ONE = PRIME_W'(1'b1);

   logic [NUM_SRC-1:0] hist_q, hist_d;
   logic [PRIME_W-1:0] primed_q, primed_d;

   // Edge detection; the first valid sample after reset only loads history
   always_comb begin
      hist_d   = sample_s;
      primed_d = (primed_q << 1) | PRIME_ONE;
      if (primed_q[PRIME_W-1]) begin
         src_edge = sample_s & ~hist_q;
      end else begin
         src_edge = {NUM_SRC{1'b0}};
      end
   end

   // History and priming flops
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         hist_q   <= {NUM_SRC{1'b0}};
         primed_q <= {PRIME_W{1'b0}};
      end else begin
         hist_q   <= hist_d;
         primed_q <= primed_d;
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl -- edge-triggered interrupt controller with claim/complete.
// Ports:
//   CLK, RST_N          : clock (rising) and synchronous active-low reset
//   src_irq[NUM_SRC]    : raw sources, bit 0 = timer
//   wr_en/addr/wr_data  : register write port (addr also selects rd_data)
//   rd_data[32]         : combinational read data
//   claim / complete    : CPU claim and end-of-service pulses
//   claim_id/claim_valid/cpu_irq : registered outputs to the CPU
// Registers: 0 ENABLE (rw), 1 PENDING (r, write-1-clear), 2 CLAIM_ID (r),
//            3 STATUS {state, cpu_irq} (r).
// Build option: INTR_CTRL_SYNC_EN adds a source synchronizer (see intr_edge_det).
module intr_ctrl
   import intr_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 5
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic [NUM_SRC-1:0] src_irq,
   input  logic               wr_en,
   input  logic [1:0]         addr,
   input  logic [31:0]        wr_data,
   output logic [31:0]        rd_data,
   input  logic               claim,
   input  logic               complete,
   output logic [ID_W-1:0]    claim_id,
   output logic               claim_valid,
   output logic               cpu_irq
);

   localparam logic [NUM_SRC-1:0] ONE_HOT0 = {{(NUM_SRC-1){1'b0}}, 1'b1};

   logic [NUM_SRC-1:0] enable_q, enable_d;
   logic [NUM_SRC-1:0] pending_q, pending_d;
   logic [NUM_SRC-1:0] src_edge_s, active_s, grant_s, wr_clr_s;
   logic [31:0]        active_ext_s;
   logic [4:0]         first_idx_s;
   state_e             state_q, state_d;
   logic [ID_W-1:0]    claim_id_q, claim_id_d;
   logic               claim_valid_q, claim_valid_d;
   logic               cpu_irq_q, cpu_irq_d;
   status_t            status_s;
   logic               unused_wr_s;

   // Only the low NUM_SRC bits of write data carry meaning
   assign unused_wr_s = ^wr_data;

   intr_edge_det #(
      .NUM_SRC (NUM_SRC)
   ) u_edge_det (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .src_irq  (src_irq),
      .src_edge (src_edge_s)
   );

   // Enabled pending sources and the lowest-index candidate
   always_comb begin
      active_s                    = pending_q & enable_q;
      active_ext_s                = 32'd0;
      active_ext_s[NUM_SRC-1:0]   = active_s;
      first_idx_s                 = lowest_set(active_ext_s);
   end

   // Controller next state; grant_s marks the pending bit taken by a claim
   always_comb begin
      state_d       = state_q;
      cpu_irq_d     = cpu_irq_q;
      claim_valid_d = claim_valid_q;
      claim_id_d    = claim_id_q;
      grant_s       = {NUM_SRC{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (|active_s) begin
               state_d   = ST_ASSERT;
               cpu_irq_d = 1'b1;
            end else begin
               cpu_irq_d = 1'b0;
            end
         end
         ST_ASSERT: begin
            if (claim) begin
               cpu_irq_d = 1'b0;
               if (|active_s) begin
                  state_d       = ST_INSERVICE;
                  claim_id_d    = ID_W'(first_idx_s);
                  claim_valid_d = 1'b1;
                  grant_s       = ONE_HOT0 << first_idx_s;
               end else begin
                  // enable was withdrawn while the request was up
                  state_d       = ST_IDLE;
                  claim_valid_d = 1'b0;
               end
            end else if (!(|active_s)) begin
               state_d   = ST_IDLE;
               cpu_irq_d = 1'b0;
            end else begin
               cpu_irq_d = 1'b1;
            end
         end
         ST_INSERVICE: begin
            if (complete) begin
               state_d       = ST_IDLE;
               claim_valid_d = 1'b0;
            end else begin
               state_d = ST_INSERVICE;
            end
         end
         default: begin
            state_d       = ST_IDLE;
            cpu_irq_d     = 1'b0;
            claim_valid_d = 1'b0;
         end
      endcase
   end

   // Register writes; a new edge outranks any clear in the same cycle
   always_comb begin
      if (wr_en && (addr == ADDR_ENABLE)) begin
         enable_d = wr_data[NUM_SRC-1:0];
      end else begin
         enable_d = enable_q;
      end
      if (wr_en && (addr == ADDR_PENDING)) begin
         wr_clr_s = wr_data[NUM_SRC-1:0];
      end else begin
         wr_clr_s = {NUM_SRC{1'b0}};
      end
      pending_d = (pending_q & ~(wr_clr_s | grant_s)) | src_edge_s;
   end

   // Read mux
   always_comb begin
      status_s = '{rsvd: 29'd0, state: state_q, cpu_irq: cpu_irq_q};
      rd_data  = 32'd0;
      case (addr)
         ADDR_ENABLE:  rd_data[NUM_SRC-1:0] = enable_q;
         ADDR_PENDING: rd_data[NUM_SRC-1:0] = pending_q;
         ADDR_CLAIM:   rd_data[ID_W-1:0]    = claim_id_q;
         ADDR_STATUS:  rd_data              = status_s;
         default:      rd_data              = 32'd0;
      endcase
   end

   // State, registers and CPU-facing outputs
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         enable_q      <= {NUM_SRC{1'b0}};
         pending_q     <= {NUM_SRC{1'b0}};
         state_q       <= ST_IDLE;
         claim_id_q    <= {ID_W{1'b0}};
         claim_valid_q <= 1'b0;
         cpu_irq_q     <= 1'b0;
      end else begin
         enable_q      <= enable_d;
         pending_q     <= pending_d;
         state_q       <= state_d;
         claim_id_q    <= claim_id_d;
         claim_valid_q <= claim_valid_d;
         cpu_irq_q     <= cpu_irq_d;
      end
   end

   assign claim_id    = claim_id_q;
   assign claim_valid = claim_valid_q;
   assign cpu_irq     = cpu_irq_q;

endmodule
